// File: rtl/dsram_responder.sv
// Data-side SRAM responder: word-organised memory with byte-lane writes and optional wait states.
// Define DSRAM_ALIGN_CHK_EN to add write-alignment checking and the addr_err output.
module dsram_responder #(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        stallreq
`ifdef DSRAM_ALIGN_CHK_EN
    ,
    output logic        addr_err
`endif
);
    localparam int         DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] BUSY   = 1'b1;

    logic [31:0]           mem_q [DEPTH];
    logic [0:0]            state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] lat_idx_q, lat_idx_d;
    logic                  lat_rd_q, lat_rd_d;
    logic [31:0]           rdata_q;

    logic [ADDR_WIDTH-1:0] req_idx;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  accept;
    logic                  is_wr;
    logic                  wr_ok;
    logic                  wr_fire;
    logic                  rd_load;
    logic                  unused_addr_bits;

    // Upper address bits alias onto the array, so the memory wraps.
    assign req_idx          = data_sram_addr[ADDR_WIDTH+1:2];
    assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

    assign accept  = rst && (state_q == IDLE) && data_sram_en;
    assign is_wr   = |data_sram_wen;
    assign wr_fire = accept && is_wr && wr_ok;

`ifdef DSRAM_ALIGN_CHK_EN
    function automatic logic wr_legal(input logic [3:0] wen, input logic [1:0] a);
        case (wen)
            4'b1111:                            wr_legal = (a == 2'b00);
            4'b0011, 4'b1100:                   wr_legal = ~a[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000: wr_legal = 1'b1;
            default:                            wr_legal = 1'b0;
        endcase
    endfunction

    logic addr_err_q;

    assign wr_ok    = wr_legal(data_sram_wen, data_sram_addr[1:0]);
    assign addr_err = addr_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= accept && is_wr && !wr_ok;
        end
    end
`else
    assign wr_ok = 1'b1;
`endif

    // Writes commit at the accept edge, even when wait states follow.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) begin
                    mem_q[req_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lat_idx_d = lat_idx_q;
        lat_rd_d  = lat_rd_q;
        rd_load   = 1'b0;
        rd_idx    = req_idx;
        if (WAIT_N == 4'd0) begin
            rd_load = accept && !is_wr;
        end else if (state_q == IDLE) begin
            if (accept) begin
                state_d   = BUSY;
                cnt_d     = WAIT_N;
                lat_idx_d = req_idx;
                lat_rd_d  = !is_wr;
            end
        end else begin
            cnt_d  = cnt_q - 4'd1;
            rd_idx = lat_idx_q;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
                rd_load = lat_rd_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            lat_idx_q <= '0;
            lat_rd_q  <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_idx_q <= lat_idx_d;
            lat_rd_q  <= lat_rd_d;
            if (rd_load) begin
                rdata_q <= mem_q[rd_idx];
            end
        end
    end

    assign data_sram_rdata = rdata_q;
    assign stallreq        = (state_q == BUSY);

endmodule
